// File: rtl/muldiv_issue_arbiter_if.sv
// rtl/muldiv_issue_arbiter_if.sv - request/response and mul/div unit signals of the issue arbiter
interface muldiv_issue_arbiter_if #(
  parameter int XLEN = 64
);
  logic              flush;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [11:0]       req_op;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [XLEN-1:0]   resp_data;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic              op_w;
  logic [1:0]        op_sgn;
  logic              unit_flush;
  logic              mul_valid;
  logic              mul_ready;
  logic              mul_done;
  logic [XLEN-1:0]   mul_hi;
  logic [XLEN-1:0]   mul_lo;
  logic              div_valid;
  logic              div_ready;
  logic              div_done;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   div_r;

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, resp_ready,
           mul_ready, mul_done, mul_hi, mul_lo,
           div_ready, div_done, div_q, div_r,
    output req_ready, resp_valid, resp_id, resp_data,
           op_a, op_b, op_w, op_sgn, unit_flush, mul_valid, div_valid
  );

  modport master (
    output flush, req_valid, req_op, req_a, req_b, resp_ready,
           mul_ready, mul_done, mul_hi, mul_lo,
           div_ready, div_done, div_q, div_r,
    input  req_ready, resp_valid, resp_id, resp_data,
           op_a, op_b, op_w, op_sgn, unit_flush, mul_valid, div_valid
  );
endinterface

// File: rtl/muldiv_issue_arbiter.sv
// rtl/muldiv_issue_arbiter.sv - round-robin sharing of one multiplier and one divider between two issue ports
module muldiv_issue_arbiter #(
  parameter int XLEN      = 64,
  parameter bit DIV0_FAST = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  muldiv_issue_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            last_grant;
  logic            cap_w;
  logic            cap_div;
  logic            cap_lo;
  logic            cap_rem;
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic            op_w_q;
  logic [1:0]      op_sgn_q;
  logic            resp_valid_q;
  logic            resp_id_q;
  logic [XLEN-1:0] resp_data_q;
  logic            mul_valid_q;
  logic            div_valid_q;
  logic            unit_flush_q;

  logic            grant0;
  logic            grant1;
  logic [1:0]      ready;
  logic            accept;
  logic [5:0]      sel_op;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic            new_w;
  logic            new_div;
  logic [1:0]      new_sgn;
  logic            b_zero;
  logic            bypass;
  logic [XLEN-1:0] bypass_data;
  logic [XLEN-1:0] unit_sel;
  logic [XLEN-1:0] unit_res;
  logic            unit_done;
  logic            handshake;

  // On contention the port that did not win last time is granted.
  assign grant0 = bus.req_valid[0] & (~bus.req_valid[1] | last_grant);
  assign grant1 = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
  assign ready  = (state == IDLE && !bus.flush) ? {grant1, grant0} : 2'b00;
  assign accept = |ready;

  assign sel_op = grant1 ? bus.req_op[11:6]         : bus.req_op[5:0];
  assign sel_a  = grant1 ? bus.req_a[2*XLEN-1:XLEN] : bus.req_a[XLEN-1:0];
  assign sel_b  = grant1 ? bus.req_b[2*XLEN-1:XLEN] : bus.req_b[XLEN-1:0];

  assign new_w   = sel_op[5];
  assign new_div = sel_op[4] & sel_op[3];

  always_comb begin
    new_sgn = 2'b11;
    if (new_div)                  new_sgn = {1'b0, ~sel_op[0]};
    else if (sel_op[1:0] == 2'b10) new_sgn = 2'b10;
    else if (sel_op[1:0] == 2'b11) new_sgn = 2'b00;
  end

  assign b_zero      = new_w ? (sel_b[31:0] == 32'd0) : (sel_b == '0);
  assign bypass      = DIV0_FAST && new_div && b_zero;
  assign bypass_data = !sel_op[1] ? '1 :
                       new_w      ? {{(XLEN-32){sel_a[31]}}, sel_a[31:0]} : sel_a;

  assign unit_sel  = cap_div ? (cap_rem ? bus.div_r : bus.div_q)
                             : (cap_lo ? bus.mul_lo : bus.mul_hi);
  assign unit_res  = cap_w ? {{(XLEN-32){unit_sel[31]}}, unit_sel[31:0]} : unit_sel;
  assign unit_done = cap_div ? bus.div_done : bus.mul_done;
  assign handshake = (mul_valid_q & bus.mul_ready) | (div_valid_q & bus.div_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cap_w        <= 1'b0;
      cap_div      <= 1'b0;
      cap_lo       <= 1'b0;
      cap_rem      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_w_q       <= 1'b0;
      op_sgn_q     <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      mul_valid_q  <= 1'b0;
      div_valid_q  <= 1'b0;
      unit_flush_q <= 1'b0;
    end else begin
      unit_flush_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_w      <= new_w;
            cap_div    <= new_div;
            cap_lo     <= (sel_op[2:0] == 3'b000);
            cap_rem    <= sel_op[1];
            op_a_q     <= sel_a;
            op_b_q     <= sel_b;
            op_w_q     <= new_w;
            op_sgn_q   <= new_sgn;
            resp_id_q  <= grant1;
            last_grant <= grant1;
            if (bypass) begin
              resp_data_q  <= bypass_data;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else begin
              mul_valid_q <= ~new_div;
              div_valid_q <= new_div;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.flush) begin
            unit_flush_q <= 1'b1;
            mul_valid_q  <= 1'b0;
            div_valid_q  <= 1'b0;
            state        <= IDLE;
          end else if (handshake) begin
            mul_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
            // A unit may answer in the same cycle it takes the operands.
            if (unit_done) begin
              resp_data_q  <= unit_res;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.flush) begin
            unit_flush_q <= 1'b1;
            state        <= IDLE;
          end else if (unit_done) begin
            resp_data_q  <= unit_res;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready || bus.flush) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.op_w       = op_w_q;
  assign bus.op_sgn     = op_sgn_q;
  assign bus.unit_flush = unit_flush_q;
  assign bus.mul_valid  = mul_valid_q;
  assign bus.div_valid  = div_valid_q;
endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// tb/tb_muldiv_issue_arbiter.sv - directed vector bench for the mul/div issue arbiter
module tb_muldiv_issue_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  muldiv_issue_arbiter_if #(.XLEN(64)) bus ();

  muldiv_issue_arbiter #(.XLEN(64), .DIV0_FAST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        port;
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] hi;
    logic [63:0] lo;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] exp;
    logic [1:0]  sgn;
    logic        byp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic present(input logic port, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    if (port) begin
      bus.req_op[11:6]  = op;
      bus.req_a[127:64] = a;
      bus.req_b[127:64] = b;
    end else begin
      bus.req_op[5:0]  = op;
      bus.req_a[63:0]  = a;
      bus.req_b[63:0]  = b;
    end
  endtask

  // Entered at the falling edge right after the accepting rising edge.
  task automatic serve(input vec_t v, input int stall, input string nm);
    logic is_div;
    is_div = v.op[4] & v.op[3];
    chk({nm, " op_a"}, bus.op_a, v.a);
    chk({nm, " op_b"}, bus.op_b, v.b);
    chk({nm, " op_sgn"}, {62'd0, bus.op_sgn}, {62'd0, v.sgn});
    chk({nm, " op_w"}, {63'd0, bus.op_w}, {63'd0, v.op[5]});
    if (v.byp) begin
      chk({nm, " bypass valids"}, {62'd0, bus.mul_valid, bus.div_valid}, 64'd0);
      chk({nm, " bypass latency"}, {63'd0, bus.resp_valid}, 64'd1);
    end else begin
      chk({nm, " issue"}, {62'd0, bus.mul_valid, bus.div_valid}, is_div ? 64'd1 : 64'd2);
      bus.mul_ready = ~is_div;
      bus.div_ready = is_div;
      @(negedge clk);
      bus.mul_ready = 1'b0;
      bus.div_ready = 1'b0;
      bus.mul_hi = v.hi;
      bus.mul_lo = v.lo;
      bus.div_q  = v.q;
      bus.div_r  = v.r;
      bus.mul_done = ~is_div;
      bus.div_done = is_div;
      chk({nm, " issue drop"}, {62'd0, bus.mul_valid, bus.div_valid}, 64'd0);
      @(negedge clk);
      bus.mul_done = 1'b0;
      bus.div_done = 1'b0;
      chk({nm, " resp_valid"}, {63'd0, bus.resp_valid}, 64'd1);
    end
    chk({nm, " resp_data"}, bus.resp_data, v.exp);
    chk({nm, " resp_id"}, {63'd0, bus.resp_id}, {63'd0, v.port});
    chk({nm, " busy req_ready"}, {62'd0, bus.req_ready}, 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, " hold"}, {bus.resp_data[60:0], bus.resp_valid, bus.resp_id, |bus.req_ready},
          {v.exp[60:0], 1'b1, v.port, 1'b0});
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({nm, " resp drop"}, {63'd0, bus.resp_valid}, 64'd0);
  endtask

  initial begin
    vec_t v;
    bus.flush = 0; bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0;
    bus.resp_ready = 0; bus.mul_ready = 0; bus.mul_done = 0; bus.mul_hi = 0; bus.mul_lo = 0;
    bus.div_ready = 0; bus.div_done = 0; bus.div_q = 0; bus.div_r = 0;

    //          port  op         a                      b                      hi                     lo                     q                      r                      exp                    sgn    byp
    vecs[0]  = '{1'b0, 6'b010000, 64'd7,                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 2'b11, 1'b0};
    vecs[1]  = '{1'b1, 6'b010011, 64'hFFFF_0000_0000_0000, 64'd2,                 64'h1234,              64'h5555,              64'd0, 64'd0, 64'h1234,              2'b00, 1'b0};
    vecs[2]  = '{1'b0, 6'b010010, 64'd9,                 64'd9,                 64'hDEAD,              64'hBEEF,              64'd0, 64'd0, 64'hDEAD,              2'b10, 1'b0};
    vecs[3]  = '{1'b1, 6'b110000, 64'h4000_0000,         64'd2,                 64'h0,                 64'h0000_0000_8000_0000, 64'd0, 64'd0, 64'hFFFF_FFFF_8000_0000, 2'b11, 1'b0};
    vecs[4]  = '{1'b0, 6'b011100, 64'd100,               64'd7,                 64'd0, 64'd0, 64'd14, 64'd2, 64'd14,                2'b01, 1'b0};
    vecs[5]  = '{1'b1, 6'b011111, 64'd100,               64'd7,                 64'd0, 64'd0, 64'd14, 64'd2, 64'd2,                 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 6'b111100, 64'd5,                 64'h1_0000_0000,       64'd0, 64'd0, 64'd3,  64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b1};
    vecs[7]  = '{1'b1, 6'b111111, 64'h8000_0001,         64'd0,                 64'd0, 64'd0, 64'd3,  64'd4, 64'hFFFF_FFFF_8000_0001, 2'b00, 1'b1};
    vecs[8]  = '{1'b0, 6'b011110, 64'h123,               64'd0,                 64'd0, 64'd0, 64'd3,  64'd4, 64'h123,               2'b01, 1'b1};
    vecs[9]  = '{1'b1, 6'b111101, 64'd10,                64'h1_0000_0003,       64'd0, 64'd0, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 6'b010001, 64'd3,                 64'd5,                 64'd7, 64'd99, 64'd0, 64'd0, 64'd7,                 2'b11, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset req_ready", {62'd0, bus.req_ready}, 64'd0);
    chk("reset outputs", {55'd0, bus.resp_valid, bus.resp_id, bus.op_w, bus.op_sgn, bus.unit_flush, bus.mul_valid, bus.div_valid}, 64'd0);
    chk("reset op_a", bus.op_a, 64'd0);
    chk("reset resp_data", bus.resp_data, 64'd0);

    // Both ports contend on every cycle: grants alternate starting from port0.
    present(1'b0, 6'b010000, 64'd11, 64'd1);
    present(1'b1, 6'b010000, 64'd22, 64'd1);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr grant", {62'd0, bus.req_ready}, (k % 2) ? 64'd2 : 64'd1);
      @(negedge clk);
      v = '{logic'(k % 2), 6'b010000, (k % 2) ? 64'd22 : 64'd11, 64'd1, 64'd0,
            (k % 2) ? 64'd22 : 64'd11, 64'd0, 64'd0, (k % 2) ? 64'd22 : 64'd11, 2'b11, 1'b0};
      serve(v, (k == 1) ? 10 : 0, "rr");
    end
    bus.req_valid = 2'b00;

    foreach (vecs[i]) begin
      @(negedge clk);
      present(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b);
      bus.req_valid = vecs[i].port ? 2'b10 : 2'b01;
      #1;
      chk("vec grant", {62'd0, bus.req_ready}, vecs[i].port ? 64'd2 : 64'd1);
      @(negedge clk);
      bus.req_valid = 2'b00;
      serve(vecs[i], 0, "vec");
    end

    // Flush while a DIVU is waiting on the divider.
    @(negedge clk);
    present(1'b0, 6'b011101, 64'd50, 64'd5);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk("flush div_valid", {63'd0, bus.div_valid}, 64'd1);
    bus.div_ready = 1'b1;
    @(negedge clk);
    bus.div_ready = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush unit_flush", {63'd0, bus.unit_flush}, 64'd1);
    bus.req_valid = 2'b01;
    #1;
    chk("flush req_ready", {62'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 2'b00;
    bus.div_q = 64'd10;
    bus.div_done = 1'b1;
    @(negedge clk);
    bus.div_done = 1'b0;
    chk("flush pulse width", {63'd0, bus.unit_flush}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flush no resp", {63'd0, bus.resp_valid}, 64'd0);
      @(negedge clk);
    end

    // Flush during RESP drops the pending response.
    present(1'b1, 6'b010000, 64'd3, 64'd3);
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.mul_ready = 1'b1;
    @(negedge clk);
    bus.mul_ready = 1'b0;
    bus.mul_lo = 64'd9;
    bus.mul_done = 1'b1;
    @(negedge clk);
    bus.mul_done = 1'b0;
    chk("resp flush pre", {bus.resp_data[62:0], bus.resp_valid}, {63'd9, 1'b1});
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("resp flush drop", {63'd0, bus.resp_valid}, 64'd0);

    // Asynchronous reset while an operation is issuing.
    present(1'b0, 6'b010011, 64'd77, 64'd2);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk("arst pre", {63'd0, bus.mul_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst outputs", {61'd0, bus.mul_valid, bus.unit_flush, bus.resp_valid}, 64'd0);
    chk("arst op_a", bus.op_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("arst no flush", {63'd0, bus.unit_flush}, 64'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
